// File: rtl/pinky_inst_encoder.sv
// Streaming PinKY instruction encoder: turns decoded fields into 16-bit instruction words,
// prefixing a PRE word whenever the immediate does not fit the 4-bit sign-extended op2 field.
module pinky_inst_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_opcode,
    input  logic [1:0]         in_cc,
    input  logic               in_imm,
    input  logic [3:0]         in_dest,
    input  logic [15:0]        in_op2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_word,
    output logic               out_is_pre,
    output logic               halted,
    output logic               err_illegal,
    output logic [COUNT_W-1:0] inst_count,
    output logic [COUNT_W-1:0] word_count
);

    localparam logic [4:0] OP_SYS = 5'b10011;
    localparam logic [4:0] OP_MAX = 5'b10100;

    typedef enum logic [1:0] {IDLE, PRE_OUT, INST_OUT, HALT} state_t;

    state_t             state_reg;
    logic               out_valid_reg;
    logic               out_is_pre_reg;
    logic               halted_reg;
    logic               err_reg;
    logic [15:0]        word_reg;
    logic [15:0]        held_reg;
    logic [COUNT_W-1:0] inst_cnt_reg;
    logic [COUNT_W-1:0] word_cnt_reg;

    logic        legal;
    logic        short_imm;
    logic        long_imm;
    logic        accept;
    logic        handoff;
    logic        word_is_sys;
    logic [15:0] inst_word;
    logic [15:0] pre_word;

    // An immediate fits when bits [15:3] are all copies of the sign bit.
    assign legal       = (in_opcode <= OP_MAX);
    assign short_imm   = (&in_op2[15:3]) | ~(|in_op2[15:3]);
    assign long_imm    = in_imm & ~short_imm;
    assign inst_word   = {in_opcode, in_cc, in_imm, in_dest, in_op2[3:0]};
    assign pre_word    = {4'b1100, in_op2[15:4]};
    assign word_is_sys = (word_reg[15:11] == OP_SYS);
    assign handoff     = out_valid_reg & out_ready;

    // Accepting while the current instruction word leaves gives one word per cycle.
    assign in_ready = reset && ((state_reg == IDLE) ||
                                ((state_reg == INST_OUT) && out_ready && !word_is_sys));
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            out_valid_reg  <= 1'b0;
            out_is_pre_reg <= 1'b0;
            halted_reg     <= 1'b0;
            err_reg        <= 1'b0;
            word_reg       <= 16'h0000;
            held_reg       <= 16'h0000;
            inst_cnt_reg   <= '0;
            word_cnt_reg   <= '0;
        end else begin
            if (handoff) begin
                word_cnt_reg <= word_cnt_reg + COUNT_W'(1);
            end

            if (accept) begin
                if (!legal) begin
                    err_reg       <= 1'b1;
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end else begin
                    inst_cnt_reg  <= inst_cnt_reg + COUNT_W'(1);
                    out_valid_reg <= 1'b1;
                    if (long_imm) begin
                        state_reg      <= PRE_OUT;
                        word_reg       <= pre_word;
                        held_reg       <= inst_word;
                        out_is_pre_reg <= 1'b1;
                    end else begin
                        state_reg      <= INST_OUT;
                        word_reg       <= inst_word;
                        out_is_pre_reg <= 1'b0;
                    end
                end
            end else begin
                case (state_reg)
                    PRE_OUT: begin
                        if (out_ready) begin
                            state_reg      <= INST_OUT;
                            word_reg       <= held_reg;
                            out_is_pre_reg <= 1'b0;
                        end
                    end
                    INST_OUT: begin
                        if (out_ready) begin
                            out_valid_reg <= 1'b0;
                            if (word_is_sys) begin
                                state_reg  <= HALT;
                                halted_reg <= 1'b1;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_word    = word_reg;
    assign out_is_pre  = out_is_pre_reg;
    assign halted      = halted_reg;
    assign err_illegal = err_reg;
    assign inst_count  = inst_cnt_reg;
    assign word_count  = word_cnt_reg;

endmodule

// File: tb/tb_pinky_inst_encoder.sv
// Randomised and directed bench for pinky_inst_encoder against a queue-based model of
// the expected word stream, handshake readiness, flags and counters.
module tb_pinky_inst_encoder;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_MOV = 5'd8;
    localparam logic [4:0] OP_SUB = 5'd17;
    localparam logic [4:0] OP_SYS = 5'd19;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [1:0]  in_cc;
    logic        in_imm;
    logic [3:0]  in_dest;
    logic [15:0] in_op2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_is_pre;
    logic        halted;
    logic        err_illegal;
    logic [15:0] inst_count;
    logic [15:0] word_count;

    pinky_inst_encoder #(.COUNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_cc(in_cc), .in_imm(in_imm),
        .in_dest(in_dest), .in_op2(in_op2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_is_pre(out_is_pre),
        .halted(halted), .err_illegal(err_illegal),
        .inst_count(inst_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        bit          pre;
    } ent_t;

    ent_t        q[$];
    bit          m_halted;
    bit          m_err;
    logic [15:0] m_inst;
    logic [15:0] m_words;
    logic [15:0] last_word;
    bit          last_pre;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_halted = 0;
        m_err    = 0;
        m_inst   = 16'd0;
        m_words  = 16'd0;
    endtask

    // Reference behaviour: the encoding follows the field arithmetic, and PRE is needed
    // exactly when the signed immediate lies outside -8..7.
    task automatic model_accept(input logic [4:0] opc, input logic [1:0] cc, input bit imm,
                                input logic [3:0] dest, input logic [15:0] op2);
        int   sval;
        ent_t e;
        if (opc > 5'd20) begin
            m_err = 1;
            return;
        end
        m_inst = m_inst + 16'd1;
        sval = int'($signed(op2));
        if (imm && (sval < -8 || sval > 7)) begin
            e.word = 16'hC000 + 16'(op2 / 16);
            e.pre  = 1;
            q.push_back(e);
        end
        e.word = 16'(int'(opc) * 2048 + int'(cc) * 512 + int'(imm) * 256 + int'(dest) * 16 + int'(op2 % 16));
        e.pre  = 0;
        q.push_back(e);
    endtask

    task automatic step(input bit iv, input logic [4:0] opc, input logic [1:0] cc, input bit imm,
                        input logic [3:0] dest, input logic [15:0] op2, input bit ordy);
        bit exp_ready;
        @(negedge clk);
        in_valid  = iv;
        in_opcode = opc;
        in_cc     = cc;
        in_imm    = imm;
        in_dest   = dest;
        in_op2    = op2;
        out_ready = ordy;
        #1;
        check_eq("halted", halted, m_halted);
        check_eq("err_illegal", err_illegal, m_err);
        check_eq("inst_count", inst_count, m_inst);
        check_eq("word_count", word_count, m_words);
        check_eq("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("out_word", out_word, q[0].word);
            check_eq("out_is_pre", out_is_pre, q[0].pre);
        end
        exp_ready = !m_halted && (q.size() == 0 ||
                    (q.size() == 1 && ordy && q[0].word[15:11] != OP_SYS));
        check_eq("in_ready", in_ready, exp_ready);
        if (ordy && q.size() != 0) begin
            last_word = q[0].word;
            last_pre  = q[0].pre;
            $display("word 0x%04h pre=%0d", last_word, last_pre);
            if (!q[0].pre && q[0].word[15:11] == OP_SYS) m_halted = 1;
            void'(q.pop_front());
            m_words = m_words + 16'd1;
        end
        if (iv && exp_ready) model_accept(opc, cc, imm, dest, op2);
    endtask

    task automatic idle(input bit ordy);
        step(0, 5'd0, 2'd0, 0, 4'd0, 16'd0, ordy);
    endtask

    function automatic logic [15:0] rand_op2();
        case ($urandom_range(0, 2))
            0:       return 16'($urandom_range(0, 15));
            1:       return 16'hFFF8 | 16'($urandom_range(0, 7));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [4:0] ropc;
        reset     = 1'b0;
        in_valid  = 0;
        in_opcode = 0;
        in_cc     = 0;
        in_imm    = 0;
        in_dest   = 0;
        in_op2    = 0;
        out_ready = 0;
        model_reset();
        last_word = 16'h0;
        last_pre  = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_word", out_word, 0);
        reset = 1'b1;

        // ADD r3,#5
        step(1, OP_ADD, 2'd0, 1, 4'd3, 16'd5, 1);
        idle(1);
        check_eq("add_word", last_word, 16'h0135);
        check_eq("add_pre", last_pre, 0);
        idle(1);
        check_eq("add_inst_count", inst_count, 1);
        check_eq("add_word_count", word_count, 1);

        // short negative, then long immediate accepted while the previous word leaves
        step(1, OP_MOV, 2'd0, 1, 4'd1, 16'hFFFD, 1);
        step(1, OP_MOV, 2'd1, 1, 4'd2, 16'h1234, 1);
        check_eq("mov_neg_word", last_word, 16'h411D);
        idle(1);
        check_eq("pre_word", last_word, 16'hC123);
        check_eq("pre_flag", last_pre, 1);
        idle(1);
        check_eq("mov_long_word", last_word, 16'h4324);
        step(1, OP_MOV, 2'd0, 1, 4'd0, 16'h0008, 1);
        idle(1);
        check_eq("pre8_word", last_word, 16'hC000);
        idle(1);
        check_eq("mov8_word", last_word, 16'h4108);

        // backpressure on a PRE word
        step(1, OP_MOV, 2'd1, 1, 4'd2, 16'h1234, 1);
        repeat (3) begin
            idle(0);
            check_eq("bp_hold_word", out_word, 16'hC123);
            check_eq("bp_in_ready", in_ready, 0);
        end
        idle(1);
        check_eq("bp_pre_word", last_word, 16'hC123);
        step(1, OP_SUB, 2'd0, 0, 4'd4, 16'hABC5, 1);
        check_eq("bp_inst_word", last_word, 16'h4324);
        idle(1);
        check_eq("sub_word", last_word, 16'h8845);

        // back-to-back short instructions
        for (int i = 0; i < 8; i++) begin
            step(1, OP_ADD, 2'(i), 1, 4'(i), 16'(i % 8), 1);
            check_eq("b2b_in_ready", in_ready, 1);
        end
        idle(1);

        // illegal opcode
        step(1, 5'b10101, 2'd0, 0, 4'd1, 16'd1, 1);
        idle(1);
        check_eq("illegal_err", err_illegal, 1);
        check_eq("illegal_no_out", out_valid, 0);

        // asynchronous reset while a PRE word is pending
        step(1, OP_MOV, 2'd0, 1, 4'd5, 16'h7FFF, 0);
        idle(0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("async_out_valid", out_valid, 0);
        check_eq("async_in_ready", in_ready, 0);
        check_eq("async_word_count", word_count, 0);
        check_eq("async_err", err_illegal, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        idle(1);

        // randomised traffic, SYS excluded so the run keeps flowing
        for (int i = 0; i < 600; i++) begin
            ropc = 5'($urandom_range(0, 23));
            if (ropc == OP_SYS) ropc = OP_ADD;
            step($urandom_range(0, 3) != 0, ropc, 2'($urandom), 1'($urandom), 4'($urandom),
                 rand_op2(), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4 && q.size() != 0; i++) idle(1);
        check_eq("drain_empty", q.size(), 0);

        // SYS halts the encoder
        step(1, OP_SYS, 2'd0, 0, 4'd0, 16'd0, 1);
        idle(1);
        check_eq("sys_word", last_word, 16'h9800);
        for (int i = 0; i < 4; i++) step(1, OP_ADD, 2'd0, 1, 4'd1, 16'd1, 1);
        check_eq("halt_flag", halted, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pinky_inst_encoder.md
Name: pinky_inst_encoder

Overview:
Streaming PinKY instruction encoder. It is the producer side of the instruction word format that stage0/stage1 decode. It takes decoded instruction fields through a valid/ready handshake and emits 16-bit instruction words, inserting a PRE word automatically when an immediate does not fit the 4-bit sign-extended field. It feeds the instruction-memory loader and test-program generators, and stops accepting input after SYS.

Parameters:
COUNT_W, 16, width of the accepted-instruction and emitted-word counters (wrap modulo 2^COUNT_W)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset (0 = in reset)
in_valid  input  1  instruction fields are valid
in_ready  output  1  encoder accepts fields this cycle
in_opcode  input  5  opcode field, legal values 00000..10100
in_cc  input  2  condition code (AL=0, S=1, NE=2, EQ=3)
in_imm  input  1  1 = Op2 is an immediate, 0 = register
in_dest  input  4  destination register
in_op2  input  16  immediate value, or register number in [3:0] ([15:4] ignored)
out_valid  output  1  out_word is valid
out_ready  input  1  consumer takes out_word this cycle
out_word  output  16  encoded word
out_is_pre  output  1  out_word is a PRE word
halted  output  1  SYS has been emitted; sticky until reset
err_illegal  output  1  sticky; an illegal opcode was presented
inst_count  output  COUNT_W  legal instructions accepted
word_count  output  COUNT_W  words handed off (out_valid & out_ready)

Behaviour:
- Reset (reset==0, asynchronous) forces: state IDLE, out_valid=0, out_word=0, out_is_pre=0, halted=0, err_illegal=0, both counters 0. This applies in every state, including mid-PRE. in_ready is 0 while reset==0.
- Instruction word layout: [15:11] opcode, [10:9] cc, [8] imm, [7:4] dest, [3:0] op2.
- PRE word layout: {2'b11, 2'b00, v[15:4]}. The decoder reconstructs the immediate as {pre, op2}.
- Short immediate: in_imm=1 and in_op2[15:3] all equal. The encoder emits one word with op2=in_op2[3:0].
- Long immediate: any other immediate. The encoder emits the PRE word first, then the instruction word with op2=in_op2[3:0].
- Register operand: the encoder emits one word with op2=in_op2[3:0]. No PRE is emitted.
- Illegal opcodes are 10101, 10110, 10111 and 11xxx (PRE is never accepted as input). An illegal opcode is consumed on handshake and sets err_illegal. It produces no output and does not increment inst_count.
- FSM states: IDLE, PRE_OUT, INST_OUT, HALT.
  - IDLE: in_ready=1, out_valid=0.
  - Accept (in_valid & in_ready) of a legal long immediate -> PRE_OUT, with the instruction word held internally.
  - Accept of any other legal instruction -> INST_OUT.
  - Accept of an illegal opcode -> IDLE.
  - PRE_OUT: out_valid=1, out_is_pre=1. On out_ready -> INST_OUT with the held word.
  - INST_OUT: out_valid=1, out_is_pre=0.
    - On out_ready with the word being SYS (10011) -> HALT.
    - On out_ready otherwise -> IDLE, or direct to the next PRE_OUT/INST_OUT if a new instruction is accepted in the same cycle.
  - HALT: in_ready=0, out_valid=0; remains here until reset.
- in_ready = (state==IDLE) | (state==INST_OUT & out_ready & word is not SYS). This gives 1 word/cycle throughput for short instructions.
- Latency: accept at edge N -> first word valid after edge N (registered output).
- Backpressure: while out_valid & !out_ready, out_word, out_is_pre and state hold stable.
- A PRE is always immediately followed by its own instruction; no other word is ever inserted between them.
- inst_count increments on accept of a legal instruction. word_count increments on each output handshake, PRE included. Both counters wrap silently.

Test Plan:
- Reset, then ADD r3,#5 with cc=AL -> one word 0x0135, out_is_pre=0; inst_count=1, word_count=1.
- MOV r1,#0xFFFD (short negative) -> 0x411D. Then MOV r2,#0x1234 with cc=S -> 0xC123 (out_is_pre=1), then 0x4324. #0x0008 also takes the PRE path (0xC000 first).
- Long immediate with out_ready held 0 for 3 cycles -> 0xC123 held stable, in_ready=0; after release the next word is 0x4324. SUB r4,r5 with in_op2=0xABC5 -> 0x8845.
- Back-to-back short instructions with out_ready=1 -> one word per cycle, in_ready stays 1.
- Opcode 10101 -> no output, err_illegal=1, counters unchanged. Then SYS -> 0x9800; afterward halted=1, in_ready=0, and further in_valid is ignored.
- reset pulled low while in PRE_OUT -> out_valid=0 immediately (asynchronously). After release, the state is IDLE with counters at 0.
